lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Load/store controller between processor_core's data-memory port and a variable-latency data memory.
- Sequences every core memory request as a two-phase access: issue, then wait for the memory's ready.
- Drives processor_core's stall_i so the core holds the request stable until the access completes.
- Generates byte enables and store-lane replication, formats load data with sign/zero extension, detects misalignment and bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in ACCESS waiting for mem_ready_i before a bus error (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
core_req_i  in  1  core memory request (processor_core mem_req_o)
core_we_i  in  1  1=store, 0=load
core_size_i  in  3  access size: 0 B, 1 H, 2 W, 4 BU, 5 HU
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, right-aligned
core_rd_o  out  32  formatted load data
core_stall_o  out  1  to processor_core stall_i
misalign_o  out  1  misaligned or illegal-size request, combinational
bus_err_o  out  1  one-cycle timeout pulse
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word address {core_addr_i[31:2],2'b00}
mem_wd_o  out  32  lane-replicated store data
mem_rd_i  in  32  raw memory read word
mem_ready_i  in  1  access complete, valid in ACCESS only

Behaviour:
- Reset: state=IDLE, timeout counter=0.
- While rst_i=1: core_stall_o=0, mem_req_o=0, mem_we_o=0, misalign_o=0, bus_err_o=0.
- All outputs other than bus_err_o are combinational from state and inputs. bus_err_o is registered from the counter compare, not from inputs.
- Bad request = core_req_i & (illegal size 3/6/7 | H/HU with addr[0]=1 | W with addr[1:0]!=0).
  - misalign_o=1.
  - mem_req_o=0 and core_stall_o=0 in the same cycle; the core traps.
  - State stays IDLE.
- Good request, IDLE:
  - mem_req_o=1, core_stall_o=1.
  - Next state ACCESS; counter cleared.
- ACCESS, mem_ready_i=1:
  - mem_req_o=1, core_stall_o=0; core captures core_rd_o this cycle.
  - Next state IDLE.
  - Minimum access = 2 cycles (1 stall cycle).
- ACCESS, mem_ready_i=0:
  - mem_req_o=1, core_stall_o=1, counter+1.
  - When counter reaches TIMEOUT_CYCLES-1: next state ERR.
- ERR, one cycle:
  - mem_req_o=0, core_stall_o=0, bus_err_o=1.
  - Next state IDLE.
- mem_ready_i outside ACCESS is ignored.
- Back-to-back memory instructions: the IDLE following completion sees the new core_req_i and stalls again. No request may be skipped or merged.
- core_req_i dropping in ACCESS (only possible via reset or a core bug): return to IDLE, mem_req_o=0.
- Asynchronous reset mid-access: immediate IDLE; mem_req_o drops without waiting for the clock edge.
- Stores, mem_we_o=core_we_i:
  - SB: be=4'b0001<<addr[1:0], wd={4{wd[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wd={2{wd[15:0]}}.
  - SW: be=4'b1111, wd=core_wd_i.
- Loads: mem_be_o uses the same encoding; mem_wd_o is don't-care.
- core_rd_o, from mem_rd_i, combinational:
  - B/BU: select byte addr[1:0], then sign- or zero-extend.
  - H/HU: select half addr[1], then sign- or zero-extend.
  - W: passthrough.
  - Stores and IDLE: 32'd0.

Decomposition:
- lsu_pkg:
  - size constants LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.
  - state enum lsu_state_t {IDLE, ACCESS, ERR}.
  - counter width function $clog2(TIMEOUT_CYCLES).
- Sub-module lsu_data_align: purely combinational byte-enable, store-replication, load extraction/extension and misalign detect.
- lsu_controller: FSM, counter, stall/req gating.

Test Plan:
- SW addr=0x100 wd=0xDEADBEEF, ready on 1st ACCESS cycle -> be=1111, wd=0xDEADBEEF, stall high exactly 1 cycle, state back to IDLE.
- SB addr=0x103 wd=0x000000A5 -> be=1000, wd=0xA5A5A5A5. LB from word 0x80FF7F01 at addr 0x101 -> core_rd_o=0x0000007F; at addr 0x103 -> 0xFFFFFF80. LBU at 0x103 -> 0x00000080.
- LH addr=0x102, mem word 0x8001_1234 -> core_rd_o=0xFFFF8001. LHU at the same address -> 0x00008001.
- LW addr=0x102 -> misalign_o=1, mem_req_o=0, stall=0. Size 3'd3 -> misalign_o=1.
- Ready withheld, TIMEOUT_CYCLES=16 -> stall held 16 cycles, then ERR: bus_err_o pulse 1 cycle, stall=0, mem_req_o=0, then IDLE.
- Two consecutive LWs with ready after 3 cycles each, plus rst_i asserted during the 2nd ACCESS -> mem_req_o drops asynchronously, state IDLE, no bus_err_o.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // Access size encodings as presented by the core.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR
    } lsu_state_t;

    // Width of the ACCESS wait counter; it never needs to hold more than n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU: byte enables, store replication,
// load extraction with sign/zero extension and alignment checking.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o,
    output logic        bad_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_i[8*off_i +: 8];
    assign half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];

    // Decode size into lane enables, replicated store data and formatted load data.
    always_comb begin
        be_o  = 4'b0000;
        wd_o  = wd_i;
        rd_o  = 32'd0;
        bad_o = 1'b1;
        case (size_i)
            LDST_B, LDST_BU: begin
                bad_o = 1'b0;
                be_o  = 4'b0001 << off_i;
                wd_o  = {4{wd_i[7:0]}};
                rd_o  = (size_i == LDST_B) ? {{24{byte_sel[7]}}, byte_sel}
                                           : {24'd0, byte_sel};
            end
            LDST_H, LDST_HU: begin
                bad_o = off_i[0];
                be_o  = off_i[1] ? 4'b1100 : 4'b0011;
                wd_o  = {2{wd_i[15:0]}};
                rd_o  = (size_i == LDST_H) ? {{16{half_sel[15]}}, half_sel}
                                           : {16'd0, half_sel};
            end
            LDST_W: begin
                bad_o = (off_i != 2'b00);
                be_o  = 4'b1111;
                wd_o  = wd_i;
                rd_o  = rd_i;
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store controller: two-phase (issue, wait-for-ready) memory access
// sequencer with core stall generation and bus timeout detection.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int             CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          req_c, stall_c;
    logic          bad;
    logic [31:0]   rd_fmt;

    lsu_data_align u_align (
        .size_i (core_size_i),
        .off_i  (core_addr_i[1:0]),
        .wd_i   (core_wd_i),
        .rd_i   (mem_rd_i),
        .be_o   (mem_be_o),
        .wd_o   (mem_wd_o),
        .rd_o   (rd_fmt),
        .bad_o  (bad)
    );

    // Next-state, wait counter and request/stall gating.
    // The counter's post-increment value is compared, so the stall lasts
    // TIMEOUT_CYCLES cycles in total (issue cycle included) before ERR.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i && !bad) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!core_req_i) begin
                    state_d = IDLE;
                end else if (mem_ready_i) begin
                    req_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CNT_LAST) begin
                        state_d   = ERR;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and the registered timeout pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign mem_req_o    = req_c & ~rst_i;
    assign core_stall_o = stall_c & ~rst_i;
    assign mem_we_o     = mem_req_o & core_we_i;
    assign misalign_o   = core_req_i & bad & ~rst_i;
    assign bus_err_o    = bus_err_q;
    assign mem_addr_o   = {core_addr_i[31:2], 2'b00};
    assign core_rd_o    = (state_q == ACCESS && !core_we_i && !rst_i) ? rd_fmt : 32'd0;

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: vector table plus corner sequences,
// load results checked through a scoreboard at completion.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, mem_rd_i;
    logic        mem_ready_i;
    logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
    logic        core_stall_o, misalign_o, bus_err_o, mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Completion monitor: a granted, unstalled request is the core's capture cycle.
    always @(negedge clk) begin
        if (!rst_i && mem_req_o && !core_stall_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=%h expected=none", core_rd_o);
            end else begin
                chk("sb_rd", core_rd_o, exp_q.pop_front());
            end
        end
    end

    task automatic apply_vec(input vec_t v, input int lat);
        int stalls;
        @(posedge clk); #1;
        core_req_i = 1'b1; core_we_i = v.we; core_size_i = v.size;
        core_addr_i = v.addr; core_wd_i = v.wd; mem_rd_i = v.mrd; mem_ready_i = 1'b0;
        @(negedge clk);
        chk("misalign", misalign_o, v.bad);
        if (v.bad) begin
            chk("bad_req", mem_req_o, 0);
            chk("bad_stall", core_stall_o, 0);
            @(posedge clk); #1 core_req_i = 1'b0;
            @(negedge clk);
            chk("bad_after_stall", core_stall_o, 0);
            return;
        end
        chk("issue_req", mem_req_o, 1);
        chk("be", mem_be_o, v.be);
        chk("addr", mem_addr_o, {v.addr[31:2], 2'b00});
        chk("we", mem_we_o, v.we);
        if (v.we) chk("wd", mem_wd_o, v.mwd);
        chk("rd_idle", core_rd_o, 0);
        exp_q.push_back(v.rd);
        stalls = core_stall_o ? 1 : 0;
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (core_stall_o) stalls++;
            chk("wait_req", mem_req_o, 1);
        end
        @(posedge clk); #1 mem_ready_i = 1'b1;
        @(negedge clk);
        if (core_stall_o) stalls++;
        chk("stall_cycles", stalls, lat + 1);
        @(posedge clk); #1 mem_ready_i = 1'b0; core_req_i = 1'b0;
        @(negedge clk);
        chk("post_req", mem_req_o, 0);
        chk("post_stall", core_stall_o, 0);
    endtask

    // With the FSM in IDLE, ready is ignored: a new request must still stall once.
    task automatic idle_ready_probe(input logic [31:0] addr, input logic [31:0] mrd);
        @(posedge clk); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = addr; mem_rd_i = mrd; mem_ready_i = 1'b1;
        @(negedge clk);
        chk("idle_ignores_ready", core_stall_o, 1);
        exp_q.push_back(mrd);
        @(posedge clk); #1;
        @(negedge clk);
        chk("probe_done_stall", core_stall_o, 0);
        @(posedge clk); #1 core_req_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    initial begin
        int stalls;
        int errs;
        // we size addr wd mrd bad be mwd rd
        vt.push_back('{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0});
        vt.push_back('{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0});
        vt.push_back('{1'b0, 3'd0, 32'h101, 32'h0, 32'h80FF7F01, 1'b0, 4'b0010, 32'h0, 32'h0000007F});
        vt.push_back('{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80});
        vt.push_back('{1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 1'b0, 4'b1000, 32'h0, 32'h00000080});
        vt.push_back('{1'b0, 3'd0, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 4'b0001, 32'h0, 32'h00000001});
        vt.push_back('{1'b0, 3'd1, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001});
        vt.push_back('{1'b0, 3'd5, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'b1100, 32'h0, 32'h00008001});
        vt.push_back('{1'b0, 3'd1, 32'h100, 32'h0, 32'h80011234, 1'b0, 4'b0011, 32'h0, 32'h00001234});
        vt.push_back('{1'b1, 3'd1, 32'h102, 32'h0000BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0});
        vt.push_back('{1'b1, 3'd0, 32'h100, 32'h123456C3, 32'h0, 1'b0, 4'b0001, 32'hC3C3C3C3, 32'h0});
        vt.push_back('{1'b0, 3'd2, 32'h104, 32'h0, 32'h12345678, 1'b0, 4'b1111, 32'h0, 32'h12345678});
        vt.push_back('{1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0});
        vt.push_back('{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0});
        vt.push_back('{1'b1, 3'd1, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0});
        vt.push_back('{1'b0, 3'd5, 32'h103, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0});
        vt.push_back('{1'b0, 3'd7, 32'h104, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0});

        // Reset with a request present: everything quiet, even for an illegal size.
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h100; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
        @(negedge clk);
        chk("rst_req", mem_req_o, 0);
        chk("rst_stall", core_stall_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_buserr", bus_err_o, 0);
        core_size_i = 3'd3; #1;
        chk("rst_misalign", misalign_o, 0);
        core_req_i = 1'b0;
        @(posedge clk); #1 rst_i = 1'b0;

        foreach (vt[i]) apply_vec(vt[i], i % 3);

        // Timeout: ready never arrives.
        @(posedge clk); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h200; mem_ready_i = 1'b0;
        stalls = 0; errs = 0;
        @(negedge clk);
        while (core_stall_o && stalls < 40) begin
            stalls++;
            if (bus_err_o) errs++;
            @(negedge clk);
        end
        chk("to_stall_cycles", stalls, 16);
        chk("to_early_err", errs, 0);
        chk("to_err_pulse", bus_err_o, 1);
        chk("to_err_req", mem_req_o, 0);
        @(posedge clk); #1 core_req_i = 1'b0;
        @(negedge clk);
        chk("to_err_end", bus_err_o, 0);
        chk("to_idle_req", mem_req_o, 0);

        // Core drops the request mid-access: back to IDLE with no memory request.
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h400; mem_ready_i = 1'b0;
        @(posedge clk); #1 core_req_i = 1'b0;
        @(negedge clk);
        chk("drop_req", mem_req_o, 0);
        idle_ready_probe(32'h404, 32'h0BADF00D);

        // Back-to-back LWs, second one interrupted by asynchronous reset.
        apply_vec('{1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D}, 3);
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h304; mem_rd_i = 32'h11111111; mem_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_access_req", mem_req_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_req", mem_req_o, 0);
        chk("async_rst_stall", core_stall_o, 0);
        chk("async_rst_buserr", bus_err_o, 0);
        @(negedge clk);
        chk("rst_hold_buserr", bus_err_o, 0);
        core_req_i = 1'b0;
        #1 rst_i = 1'b0;
        idle_ready_probe(32'h308, 32'h55AA00FF);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
